// File: rtl/fp_convert_seq.sv
// fp_convert_seq: converts a 12-bit two's-complement word into an 8-bit
// sign/exponent/significand float (value = F * 2^E). The work is split into
// ABS, NORM and ROUND states, with valid/ready handshakes on both sides.
module fp_convert_seq #(
  parameter bit FAST_NORM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] d_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        s,
  output logic [2:0]  e,
  output logic [3:0]  f,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABS   = 3'd1,
    ST_NORM  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [11:0] d_r, d_s;
  logic        sign_r, sign_s;
  logic [10:0] mag_r, mag_s;
  logic [2:0]  exp_r, exp_s;
  logic        s_r, s_s;
  logic [2:0]  e_r, e_s;
  logic [3:0]  f_r, f_s;
  logic        out_valid_r, out_valid_s;
  logic        busy_r, busy_s;
  logic        in_ready_r, in_ready_s;

  // Magnitude of a two's-complement word; -2048 has no 11-bit magnitude and
  // is clamped to the largest one.
  function automatic logic [10:0] abs_sat(input logic [11:0] d);
    logic [11:0] neg;
    neg = 12'd0 - d;
    if (d == 12'h800) begin
      abs_sat = 11'h7FF;
    end else if (d[11]) begin
      abs_sat = neg[10:0];
    end else begin
      abs_sat = d[10:0];
    end
  endfunction

  // Single-step normalisation: shift count is 10 minus the leading-one
  // position, capped at 7 so the exponent bottoms out at 0.
  function automatic logic [13:0] norm_fast(input logic [10:0] m);
    logic [2:0] sh;
    sh = 3'd7;
    for (int i = 0; i < 11; i++) begin
      if (m[i]) begin
        if (i < 3) begin
          sh = 3'd7;
        end else begin
          sh = 3'(10 - i);
        end
      end else begin
        sh = sh;
      end
    end
    norm_fast = {m << sh, 3'd7 - sh};
  endfunction

  // Round-to-nearest on the top four bits; a carry out of F renormalises to
  // 4'h8 with exponent+1, saturating at the largest representable value.
  function automatic logic [6:0] round_fields(input logic [10:0] m,
                                              input logic [2:0]  ex);
    logic [3:0] fr;
    fr = m[10:7];
    if (!m[6]) begin
      round_fields = {ex, fr};
    end else if (fr != 4'hF) begin
      round_fields = {ex, fr + 4'd1};
    end else if (ex == 3'd7) begin
      round_fields = {3'd7, 4'hF};
    end else begin
      round_fields = {ex + 3'd1, 4'h8};
    end
  endfunction

  // Next-state and datapath update for the conversion sequence.
  always_comb begin
    state_s = state_r;
    d_s     = d_r;
    sign_s  = sign_r;
    mag_s   = mag_r;
    exp_s   = exp_r;
    s_s     = s_r;
    e_s     = e_r;
    f_s     = f_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          d_s     = d_in;
          state_s = ST_ABS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ABS: begin
        sign_s  = d_r[11];
        mag_s   = abs_sat(d_r);
        exp_s   = 3'd7;
        state_s = ST_NORM;
      end
      ST_NORM: begin
        if (FAST_NORM) begin
          {mag_s, exp_s} = norm_fast(mag_r);
          state_s        = ST_ROUND;
        end else if (mag_r[10] || (exp_r == 3'd0)) begin
          state_s = ST_ROUND;
        end else begin
          mag_s   = {mag_r[9:0], 1'b0};
          exp_s   = exp_r - 3'd1;
          state_s = ST_NORM;
        end
      end
      ST_ROUND: begin
        s_s        = sign_r;
        {e_s, f_s} = round_fields(mag_r, exp_r);
        state_s    = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    out_valid_s = (state_s == ST_DONE);
    busy_s      = (state_s != ST_IDLE);
    in_ready_s  = (state_s == ST_IDLE);
  end

  // State, datapath and output registers; reset clears everything so an
  // aborted conversion leaves no partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      d_r         <= 12'd0;
      sign_r      <= 1'b0;
      mag_r       <= 11'd0;
      exp_r       <= 3'd0;
      s_r         <= 1'b0;
      e_r         <= 3'd0;
      f_r         <= 4'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      d_r         <= d_s;
      sign_r      <= sign_s;
      mag_r       <= mag_s;
      exp_r       <= exp_s;
      s_r         <= s_s;
      e_r         <= e_s;
      f_r         <= f_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      in_ready_r  <= in_ready_s;
    end
  end

  assign s         = s_r;
  assign e         = e_r;
  assign f         = f_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign in_ready  = in_ready_r;

endmodule

// File: tb/tb_fp_convert_seq.sv
// Bench for fp_convert_seq (FAST_NORM=0): random and directed words are
// converted by an arithmetic reference model and the DUT result, its latency
// and its handshake behaviour are compared every cycle a result is presented.
module tb_fp_convert_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] d_in;
  logic        out_valid;
  logic        out_ready;
  logic        s;
  logic [2:0]  e;
  logic [3:0]  f;
  logic        busy;

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
    int         lat;
    time        acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rdy_mode = 0;  // 0 random, 1 held low, 2 held high

  fp_convert_seq #(.FAST_NORM(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .e(e), .f(f), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: signed value, magnitude clamp, doubling until >= 1024 (at most
  // 7 times), then round half-up on the bit below the kept four.
  function automatic exp_t model(input logic [11:0] d);
    exp_t r;
    int v, m, n, ex, fr;
    v = d[11] ? int'(d) - 4096 : int'(d);
    m = (v < 0) ? -v : v;
    if (m > 2047) m = 2047;
    n = 0;
    while (m < 1024 && n < 7) begin
      m = m * 2;
      n++;
    end
    ex = 7 - n;
    fr = m / 128;
    if ((m / 64) % 2 == 1) begin
      fr++;
      if (fr == 16) begin
        fr = 8;
        ex++;
        if (ex == 8) begin
          ex = 7;
          fr = 15;
        end
      end
    end
    r.s = (v < 0);
    r.e = ex[2:0];
    r.f = fr[3:0];
    r.lat = n + 3;
    r.acc = 0;
    return r;
  endfunction

  task automatic pin(input logic [11:0] d, input logic ps, input int pe,
                     input int pf, input int pl);
    exp_t r;
    r = model(d);
    chk("model_pin_sef", {r.s, r.e, r.f}, {ps, pe[2:0], pf[3:0]});
    chk("model_pin_lat", r.lat, pl);
  endtask

  // Offer one word, wait (bounded) for acceptance and log its expectation.
  task automatic send(input logic [11:0] d);
    int k;
    k = 0;
    while (k < 300) begin
      @(posedge clk);
      #1;
      if (in_ready) break;
      k++;
    end
    chk("in_ready_timeout", int'(k < 300), 1);
    if (k < 300) begin
      exp_t r;
      in_valid = 1'b1;
      d_in     = d;
      r = model(d);
      @(posedge clk);
      r.acc = $time;
      exp_q.push_back(r);
      #1;
      in_valid = 1'b0;
      d_in     = 12'($urandom);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Consumer: out_ready pattern chosen by rdy_mode.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Compare process: on every presented result check fields, handshake
  // flags and latency against the head of the expectation queue.
  initial begin
    bit first;
    exp_t t;
    first = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        first = 1'b1;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", int'(out_valid), 0);
        end else begin
          t = exp_q[0];
          chk("sef", {s, e, f}, {t.s, t.e, t.f});
          chk("in_ready_in_done", int'(in_ready), 0);
          chk("busy_in_done", int'(busy), 1);
          if (first) begin
            chk("latency", int'(($time - t.acc - 5) / 10), t.lat);
            first = 1'b0;
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            first = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    d_in     = 12'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {s, e, f, out_valid, busy, in_ready}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 1);

    // Hand-computed values that pin the reference model.
    pin(12'h000, 1'b0, 0, 0, 10);
    pin(12'h07D, 1'b0, 4, 8, 7);
    pin(12'h800, 1'b1, 7, 15, 3);
    pin(12'h7FF, 1'b0, 7, 15, 3);
    pin(12'hFE6, 1'b1, 1, 13, 9);

    // Directed corner words through the DUT.
    send(12'h000);
    send(12'h07D);
    send(12'h800);
    send(12'h7FF);
    send(12'hFE6);
    drain();

    // Result held in DONE for 10 cycles; an in_valid pulse must be ignored.
    rdy_mode = 1;
    send(12'h0A5);
    begin
      int k;
      k = 0;
      while (!out_valid && k < 30) begin
        @(negedge clk);
        k++;
      end
      chk("hold_reach_done", int'(out_valid), 1);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      in_valid = (k == 3);
      d_in     = 12'h123;
    end
    in_valid = 1'b0;
    chk("hold_valid", int'(out_valid), 1);
    chk("hold_in_ready", int'(in_ready), 0);
    rdy_mode = 2;
    drain();
    rdy_mode = 0;

    // Asynchronous abort in the middle of normalisation.
    send(12'h001);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {s, e, f, out_valid, busy, in_ready}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(12'h3C4);
    drain();

    // Randomised traffic, biased towards small magnitudes now and then.
    for (int i = 0; i < 150; i++) begin
      logic [11:0] d;
      d = 12'($urandom);
      if ($urandom_range(0, 3) == 0) d = 12'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) d = 12'd0 - 12'($urandom_range(0, 40));
      send(d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
